// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: datapath widths and the fetch FIFO entry layout.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and occupancy count; a full FIFO accepts push+pop together.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= (r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wptr] <= din;
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(push && full && !w_do_pop && !flush))
      else $error("sync_fifo overflow");
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: sequential PC generation, in-order imem requests, instruction buffering
// toward decode, and redirect handling that discards stale in-flight responses.
module instr_fetch_queue import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);
  localparam int OW = $clog2(MAX_OUTST+1);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [OW-1:0]   r_outst, r_drop;

  logic [OW-1:0]   w_outst_nxt, w_tag_cnt;
  logic [CW-1:0]   w_fifo_cnt;
  logic [31:0]     w_resv;
  logic [XLEN-1:0] w_tag_pc;
  logic            w_fire, w_keep, w_pop;
  logic            w_fifo_empty, w_fifo_full, w_tag_empty, w_tag_full;
  fetch_entry_t    w_push_ent, w_head;

  // Non-stale requests in flight already own a FIFO slot, so responses can never overflow.
  assign w_resv         = 32'(r_outst) - 32'(r_drop) + 32'(w_fifo_cnt);
  assign imem_req_valid = reset && !redirect_valid && (w_resv < 32'(DEPTH)) &&
                          (32'(r_outst) < 32'(MAX_OUTST));
  assign imem_req_addr  = r_fetch_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;
  assign w_outst_nxt    = r_outst + OW'(w_fire) - OW'(imem_resp_valid);
  assign w_keep         = imem_resp_valid && (r_drop == '0) && !redirect_valid;

  assign w_push_ent.pc    = w_tag_pc;
  assign w_push_ent.instr = imem_resp_instr;

  assign id_valid = !w_fifo_empty;
  assign w_pop    = id_valid && id_ready;
  assign id_instr = w_fifo_empty ? '0 : w_head.instr;
  assign id_pc    = w_fifo_empty ? '0 : w_head.pc;

  // Tag queue is never flushed: stale tags retire one-for-one with stale responses.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tag_q (
    .clk(clk), .rst_n(reset),
    .push(w_fire), .din(r_fetch_pc), .pop(imem_resp_valid), .flush(1'b0),
    .dout(w_tag_pc), .count(w_tag_cnt), .full(w_tag_full), .empty(w_tag_empty)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
    .clk(clk), .rst_n(reset),
    .push(w_keep), .din(w_push_ent), .pop(w_pop), .flush(redirect_valid),
    .dout(w_head), .count(w_fifo_cnt), .full(w_fifo_full), .empty(w_fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        r_drop     <= w_outst_nxt;
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (imem_resp_valid && (r_drop != '0)) r_drop <= r_drop - OW'(1);
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      assert (!(imem_resp_valid && w_tag_empty)) else $error("response without request");
      assert (!(w_fire && w_tag_full)) else $error("tag queue overflow");
      assert (w_tag_cnt == r_outst) else $error("tag count out of sync");
      assert (!(w_keep && w_fifo_full && !w_pop)) else $error("instruction fifo overflow");
    end
  end
endmodule
